// File: rtl/inst_fetcher_pkg.sv
// inst_fetcher_pkg: opcodes, FSM encoding and next-PC predecode shared by the fetch stage.
package inst_fetcher_pkg;
  localparam int BHT_BW_DEF = 6;
  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam logic [6:0] J_TYPE = 7'b1101111;
  typedef enum logic [1:0] {IF_IDLE, IF_WAIT, IF_HOLD, IF_DROP} if_state_e;
  function automatic logic [31:0] predict_pc(input logic [31:0] i, input logic [31:0] pc, input logic taken);
    logic [31:0] j_imm, b_imm;
    j_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    b_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    return i[6:0] == J_TYPE ? pc + j_imm : (i[6:0] == B_TYPE && taken) ? pc + b_imm : pc + 32'd4;
  endfunction
endpackage

// File: rtl/inst_fetcher_branch_predictor.sv
// inst_fetcher_branch_predictor: 2-bit saturating BHT, async read by fetch pc, update from ROB commit.
module inst_fetcher_branch_predictor
  import inst_fetcher_pkg::*;
#(
  parameter int BHT_BW = BHT_BW_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] rd_pc_i,
  output logic        rd_taken_o,
  input  logic        upd_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i
);
  logic [1:0] bht_q [2**BHT_BW];
  logic [BHT_BW-1:0] upd_idx;
  logic [1:0] cnt, cnt_d;
  logic unused_pc_bits;
  assign unused_pc_bits = ^{upd_pc_i[31:BHT_BW+2], upd_pc_i[1:0], rd_pc_i[31:BHT_BW+2], rd_pc_i[1:0]};
  assign upd_idx = upd_pc_i[BHT_BW+1:2];
  assign cnt = bht_q[upd_idx];
  assign cnt_d = upd_taken_i ? (cnt == 2'b11 ? cnt : cnt + 2'd1) : (cnt == 2'b00 ? cnt : cnt - 2'd1);
  // Read sees the pre-edge array, so a same-index update is invisible until next cycle.
  assign rd_taken_o = bht_q[rd_pc_i[BHT_BW+1:2]][1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int k = 0; k < 2**BHT_BW; k++) bht_q[k] <= 2'b01;
    else if (rdy && upd_i) bht_q[upd_idx] <= cnt_d;
  end
endmodule

// File: rtl/inst_fetcher.sv
// inst_fetcher: holds the PC, fetches one word per memory transaction and issues it with a predicted next PC.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int          BHT_BW   = BHT_BW_DEF,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data,
  input  logic        stall,
  output logic        inst_flag,
  output logic [31:0] inst,
  output logic [31:0] inst_IF_pc,
  output logic [31:0] inst_IF_prd_pc,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  input  logic        brc_upd,
  input  logic [31:0] brc_upd_pc,
  input  logic        brc_upd_taken
);
  if_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, inst_q, inst_d, ipc_q, ipc_d, iprd_q, iprd_d;
  logic [31:0] buf_inst_q, buf_inst_d, buf_prd_q, buf_prd_d;
  logic req_q, req_d, flag_q, flag_d, bp_taken, latch, issue;

  inst_fetcher_branch_predictor #(.BHT_BW(BHT_BW)) u_bp (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rd_pc_i(pc_q), .rd_taken_o(bp_taken),
    .upd_i(brc_upd), .upd_pc_i(brc_upd_pc), .upd_taken_i(brc_upd_taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IF_IDLE;
      pc_q <= RESET_PC;
      req_q <= 1'b0;
      addr_q <= '0;
      flag_q <= 1'b0;
      inst_q <= '0;
      ipc_q <= '0;
      iprd_q <= '0;
      buf_inst_q <= '0;
      buf_prd_q <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_q <= req_d;
      addr_q <= addr_d;
      flag_q <= flag_d;
      inst_q <= inst_d;
      ipc_q <= ipc_d;
      iprd_q <= iprd_d;
      buf_inst_q <= buf_inst_d;
      buf_prd_q <= buf_prd_d;
    end else begin
      flag_q <= 1'b0;
    end
  end

  // A flush with a request still in flight must swallow the late response in DROP.
  always_comb begin
    state_d = rollback ? (((state_q == IF_WAIT || state_q == IF_DROP) && !mc_done) ? IF_DROP : IF_IDLE)
            : state_q == IF_IDLE ? IF_WAIT
            : state_q == IF_WAIT ? (mc_done ? IF_HOLD : IF_WAIT)
            : state_q == IF_HOLD ? (stall ? IF_HOLD : IF_IDLE)
            : (mc_done ? IF_IDLE : IF_DROP);
  end

  always_comb begin
    latch = state_q == IF_WAIT && mc_done && !rollback;
    issue = state_q == IF_HOLD && !stall && !rollback;
    req_d = rollback ? 1'b0 : state_q == IF_IDLE ? 1'b1 : latch ? 1'b0 : req_q;
    addr_d = (state_q == IF_IDLE && !rollback) ? pc_q : addr_q;
    buf_inst_d = latch ? mc_data : buf_inst_q;
    buf_prd_d = latch ? predict_pc(mc_data, pc_q, bp_taken) : buf_prd_q;
    flag_d = issue;
    inst_d = issue ? buf_inst_q : inst_q;
    ipc_d = issue ? pc_q : ipc_q;
    iprd_d = issue ? buf_prd_q : iprd_q;
    pc_d = rollback ? rollback_pc : issue ? buf_prd_q : pc_q;
  end

  assign mc_req = req_q;
  assign mc_addr = addr_q;
  assign inst_flag = flag_q;
  assign inst = inst_q;
  assign inst_IF_pc = ipc_q;
  assign inst_IF_prd_pc = iprd_q;
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: directed fetch, prediction, stall, rollback and reset sequences with hand-computed expectations.
module tb_inst_fetcher;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic mc_req, mc_done = 1'b0, stall = 1'b0, inst_flag;
  logic [31:0] mc_addr, mc_data = '0, inst, inst_IF_pc, inst_IF_prd_pc;
  logic rollback = 1'b0, brc_upd = 1'b0, brc_upd_taken = 1'b0;
  logic [31:0] rollback_pc = '0, brc_upd_pc = '0;
  int n_cmp = 0, n_err = 0;

  localparam logic [31:0] ADDI   = 32'h00100093;
  localparam logic [31:0] JAL8   = 32'h0080006F;
  localparam logic [31:0] JALM4  = 32'hFFDFF06F;
  localparam logic [31:0] JALM16 = 32'hFF1FF06F;
  localparam logic [31:0] JAL32  = 32'h0200006F;
  localparam logic [31:0] BEQ16  = 32'h00000863;
  localparam logic [31:0] JUNK   = 32'hDEADBEEF;

  inst_fetcher dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mc_req(mc_req), .mc_addr(mc_addr), .mc_done(mc_done), .mc_data(mc_data),
    .stall(stall), .inst_flag(inst_flag), .inst(inst),
    .inst_IF_pc(inst_IF_pc), .inst_IF_prd_pc(inst_IF_prd_pc),
    .rollback(rollback), .rollback_pc(rollback_pc),
    .brc_upd(brc_upd), .brc_upd_pc(brc_upd_pc), .brc_upd_taken(brc_upd_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] addr, input string tag);
    int n = 0;
    while (!mc_req && n < 50) begin tick(); n++; end
    chk($sformatf("%s_req", tag), {31'd0, mc_req}, 32'd1);
    chk($sformatf("%s_addr", tag), mc_addr, addr);
  endtask

  task automatic respond(input logic [31:0] d, input int lat);
    repeat (lat) tick();
    mc_data = d;
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    mc_data = '0;
  endtask

  task automatic wait_flag(input logic [31:0] d, input logic [31:0] pc, input logic [31:0] prd, input string tag);
    int n = 0;
    while (!inst_flag && n < 50) begin tick(); n++; end
    chk($sformatf("%s_flag", tag), {31'd0, inst_flag}, 32'd1);
    chk($sformatf("%s_inst", tag), inst, d);
    chk($sformatf("%s_pc", tag), inst_IF_pc, pc);
    chk($sformatf("%s_prd", tag), inst_IF_prd_pc, prd);
    tick();
    chk($sformatf("%s_pulse", tag), {31'd0, inst_flag}, 32'd0);
  endtask

  task automatic fetch(input logic [31:0] d, input logic [31:0] pc, input logic [31:0] prd, input int lat, input string tag);
    wait_req(pc, tag);
    respond(d, lat);
    wait_flag(d, pc, prd, tag);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken);
    brc_upd = 1'b1;
    brc_upd_pc = pc;
    brc_upd_taken = taken;
    tick();
    brc_upd = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk($sformatf("%s_req", tag), {31'd0, mc_req}, 32'd0);
    chk($sformatf("%s_addr", tag), mc_addr, 32'd0);
    chk($sformatf("%s_flag", tag), {31'd0, inst_flag}, 32'd0);
    chk($sformatf("%s_inst", tag), inst, 32'd0);
    chk($sformatf("%s_pc", tag), inst_IF_pc, 32'd0);
    chk($sformatf("%s_prd", tag), inst_IF_prd_pc, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    // Straight-line fetch, then walk to 0x10
    fetch(ADDI, 32'h0, 32'h4, 3, "addi0");
    fetch(ADDI, 32'h4, 32'h8, 1, "addi4");
    fetch(ADDI, 32'h8, 32'hC, 2, "addi8");
    fetch(ADDI, 32'hC, 32'h10, 0, "addic");
    fetch(JAL8, 32'h10, 32'h18, 1, "jal8");
    fetch(ADDI, 32'h18, 32'h1C, 1, "addi18");
    fetch(ADDI, 32'h1C, 32'h20, 1, "addi1c");
    // BHT training on the branch at 0x20
    fetch(BEQ16, 32'h20, 32'h24, 1, "beq_untrained");
    upd(32'h20, 1'b1);
    upd(32'h20, 1'b1);
    fetch(JALM4, 32'h24, 32'h20, 1, "jal_m4");
    fetch(BEQ16, 32'h20, 32'h30, 1, "beq_taken");
    upd(32'h20, 1'b0);
    upd(32'h20, 1'b0);
    fetch(JALM16, 32'h30, 32'h20, 1, "jal_m16");
    fetch(BEQ16, 32'h20, 32'h24, 1, "beq_weak");
    // Downstream stall holds the fetched word
    wait_req(32'h24, "stall");
    stall = 1'b1;
    respond(ADDI, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_hold%0d", i), {31'd0, inst_flag}, 32'd0);
      tick();
    end
    stall = 1'b0;
    tick();
    chk("stall_flag", {31'd0, inst_flag}, 32'd1);
    chk("stall_inst", inst, ADDI);
    chk("stall_pc", inst_IF_pc, 32'h24);
    chk("stall_prd", inst_IF_prd_pc, 32'h28);
    tick();
    chk("stall_pulse", {31'd0, inst_flag}, 32'd0);
    // Rollback during WAIT: late junk response is dropped
    wait_req(32'h28, "rb_wait");
    rollback = 1'b1;
    rollback_pc = 32'h100;
    tick();
    rollback = 1'b0;
    chk("rb_drop_req", {31'd0, mc_req}, 32'd0);
    chk("rb_drop_flag", {31'd0, inst_flag}, 32'd0);
    tick();
    respond(JUNK, 0);
    chk("rb_junk_flag", {31'd0, inst_flag}, 32'd0);
    fetch(ADDI, 32'h100, 32'h104, 1, "rb_refetch");
    // Rollback coinciding with mc_done goes straight to IDLE
    wait_req(32'h104, "rb2_wait");
    tick();
    rollback = 1'b1;
    rollback_pc = 32'h100;
    mc_done = 1'b1;
    mc_data = JUNK;
    tick();
    rollback = 1'b0;
    mc_done = 1'b0;
    mc_data = '0;
    chk("rb2_req_low", {31'd0, mc_req}, 32'd0);
    chk("rb2_flag", {31'd0, inst_flag}, 32'd0);
    tick();
    chk("rb2_req_high", {31'd0, mc_req}, 32'd1);
    chk("rb2_addr", mc_addr, 32'h100);
    respond(ADDI, 1);
    wait_flag(ADDI, 32'h100, 32'h104, "rb2_refetch");
    // Async reset mid-WAIT restores everything, including the BHT
    upd(32'h20, 1'b1);
    upd(32'h20, 1'b1);
    wait_req(32'h104, "arst_wait");
    #2 rst = 1'b1;
    #1 chk_reset("arst");
    @(posedge clk);
    #1 rst = 1'b0;
    fetch(JAL32, 32'h0, 32'h20, 1, "arst_jal");
    fetch(BEQ16, 32'h20, 32'h24, 1, "arst_beq");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
